instr_loader: RTL
=================

Name: instr_loader

Overview:
- Writer side of the byte-addressed instruction memory; the fetch path reads that memory asynchronously as four big-endian bytes at PC..PC+3.
- Accepts a program as a valid/ready byte stream and writes it one byte per cycle into the memory's write port, starting at a base address.
- Verifies a trailing 8-bit checksum and holds the CPU in reset while loading.
- Sits between the host link (UART receiver or testbench) and the instruction memory write port.

Parameters:
- ADDR_WIDTH, 16, byte address width of the instruction memory (2**ADDR_WIDTH bytes).
- DATA_WIDTH, 8, byte width. Fixed at 8; the checksum is defined on 8 bits.
- LEN_WIDTH, 17, width of the byte count. Must be ≥ ADDR_WIDTH+1 so a full-memory load is expressible.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  begin a load; sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first byte address, latched on start.
- byte_count_i  in  LEN_WIDTH  payload length in bytes, latched on start.
- rx_valid_i  in  1  stream byte valid.
- rx_data_i  in  DATA_WIDTH  stream byte.
- rx_ready_o  out  1  loader accepts a byte this cycle.
- mem_we_o  out  1  memory byte write enable.
- mem_addr_o  out  ADDR_WIDTH  memory byte address.
- mem_data_o  out  DATA_WIDTH  memory byte data.
- cpu_hold_o  out  1  keep the CPU in reset.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse at the end of a load.
- err_o  out  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters and checksum 0.
- States and transitions:
  - IDLE: on start_i, latch base and count, clear err_o and checksum.
    - count > 2**ADDR_WIDTH: go to DONE with err_o=1; no writes.
    - count == 0: go to CHECK.
    - otherwise: go to LOAD.
  - LOAD: rx_ready_o=1.
    - Each handshake (rx_valid_i & rx_ready_o) registers mem_we_o=1, mem_addr_o=current address, mem_data_o=byte. The write is visible on the port the cycle after the handshake (latency 1).
    - Address increments modulo 2**ADDR_WIDTH and wraps silently.
    - Remaining count decrements; checksum += byte mod 256.
    - The handshake that takes remaining to 0 moves the state to CHECK.
  - CHECK: rx_ready_o=1; no memory write.
    - On handshake, pass if (checksum + byte) mod 256 == 0, else set err_o=1.
    - Next state DONE.
  - DONE: done_o=1 for exactly one cycle; then IDLE.
- mem_we_o is 0 in every cycle not immediately following a LOAD handshake. Cycles with no valid byte (stall) produce no write and hold the address.
- rx_ready_o is combinational from state only, never from rx_valid_i.
- Throughput is one byte per cycle with rx_valid_i held high. An N-byte payload needs N+1 handshakes.
- Byte order: stream order equals memory address order. The first byte at base is the most significant byte of the instruction at base.
- cpu_hold_o = busy_o = (state != IDLE). It deasserts in the cycle after the done_o pulse.
- start_i while busy_o=1 is ignored.
- Asserting rst mid-load returns to IDLE immediately and clears all outputs. Bytes already written stay in memory; no rollback.
- err_o remains set after DONE until the next accepted start.

Decomposition:
- Package instr_loader_pkg:
  - state enum: IDLE, LOAD, CHECK, DONE.
  - CSUM_INIT = 8'h00.
  - function for the modulo-256 checksum pass test.
- Single module; no sub-module is warranted.

Test Plan:
1. Basic load: base=0x0000, count=4, bytes 13 05 00 00, checksum byte 0xE8 (0x13+0x05=0x18; 0x18+0xE8=0x100) → writes at 0..3 with data 13,05,00,00 on consecutive cycles; done_o pulses; err_o=0; memory read at PC=0 returns 0x13050000.
2. Bad checksum: same payload, checksum byte 0x00 → 4 writes occur, done_o pulses, err_o=1 and stays 1 until the next start.
3. Stall and wrap: base=0xFFFE, count=4, rx_valid_i toggled every other cycle → writes at addresses FFFE, FFFF, 0000, 0001 only on the cycle after each handshake; no write while valid is low.
4. Edge counts:
   - count=0 with checksum byte 0x00 → no writes, done_o pulses, err_o=0.
   - count=0x10001 → no writes, done_o pulses, err_o=1.
5. Busy start and reset: start_i pulsed mid-load → ignored. rst asserted after 2 of 4 bytes → all outputs 0 immediately, cpu_hold_o=0; a fresh load then completes normally.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared state encoding and checksum helper for the instruction loader
package instr_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE
    } state_t;

    localparam logic [7:0] CSUM_INIT = 8'h00;

    // A load is good when the running sum plus the trailing byte wraps to zero.
    function automatic logic csum_pass(input logic [7:0] sum, input logic [7:0] check_byte);
        logic [7:0] total;
        total = sum + check_byte;
        return total == 8'h00;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - program byte stream in, instruction memory byte write port out
interface instr_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  rx_valid_i;
    logic [DATA_WIDTH-1:0] rx_data_i;
    logic                  rx_ready_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_data_o;

    modport master (
        output rx_valid_i,
        output rx_data_i,
        input  rx_ready_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_data_o
    );

    modport slave (
        input  rx_valid_i,
        input  rx_data_i,
        output rx_ready_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_data_o
    );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - streams a checksummed program into instruction memory while holding the CPU
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  byte_count_i,
    instr_loader_if.slave         bus,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [LEN_WIDTH-1:0] MEM_BYTES = LEN_WIDTH'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [DATA_WIDTH-1:0] csum_q;
    logic                  err_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  rx_ready;
    logic                  handshake;
    logic                  accept_start;
    logic                  oversize;

    assign oversize  = byte_count_i > MEM_BYTES;
    assign handshake = bus.rx_valid_i & rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready depends on state alone so the host never sees a valid->ready loop.
    always_comb begin
        state_d      = state_q;
        rx_ready     = 1'b0;
        accept_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    accept_start = 1'b1;
                    if (oversize) begin
                        state_d = DONE;
                    end else if (byte_count_i == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                rx_ready = 1'b1;
                if (bus.rx_valid_i && remaining_q == LEN_WIDTH'(1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                rx_ready = 1'b1;
                if (bus.rx_valid_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            csum_q      <= CSUM_INIT;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            we_q <= 1'b0;
            if (accept_start) begin
                addr_q      <= base_addr_i;
                remaining_q <= byte_count_i;
                csum_q      <= CSUM_INIT;
                err_q       <= oversize;
            end else if (handshake && state_q == LOAD) begin
                // Address wraps at the top of memory; no bounds error is raised.
                we_q        <= 1'b1;
                wr_addr_q   <= addr_q;
                wr_data_q   <= bus.rx_data_i;
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                remaining_q <= remaining_q - LEN_WIDTH'(1);
                csum_q      <= csum_q + bus.rx_data_i;
            end else if (handshake && state_q == CHECK) begin
                err_q <= !csum_pass(csum_q, bus.rx_data_i);
            end
        end
    end

    assign bus.rx_ready_o = rx_ready;
    assign bus.mem_we_o   = we_q;
    assign bus.mem_addr_o = wr_addr_q;
    assign bus.mem_data_o = wr_data_q;
    assign busy_o         = (state_q != IDLE);
    assign cpu_hold_o     = busy_o;
    assign done_o         = (state_q == DONE);
    assign err_o          = err_q;

endmodule
